// File: rtl/isa_encoder.sv
`default_nettype none
// ============================================================================
// Module      : isa_encoder
// Description : Streams assembler-level instructions (op, ra, rb, imm) into
//               an instruction memory as 9-bit machine words. A start pulse
//               opens a program load. Each accepted instruction is written
//               one cycle later at a write pointer that starts at START_ADDR.
//               The load ends on in_last, or on overflow at the top address.
// Macro       : ISA_ENCODER_BRANCH_EXPAND_EN - when defined, bne (op 110)
//               expands into {set imm} followed by {bne ra,rb}.
// Ports       : clk, reset_n (sync, active-low)
//               start                         - begin/restart a load
//               in_valid/in_ready             - instruction handshake
//               in_op/in_ra/in_rb/in_imm/in_last - instruction fields
//               wr_en/wr_addr/wr_data         - instruction-memory write
//               busy/done/ovf                 - status (ovf is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module isa_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [5:0]        in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EXP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_PTR_INIT = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] C_PTR_MAX  = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [8:0]          wr_data_q, wr_data_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  // Second word of an expanded branch, held through the EXP cycle.
  logic [8:0]          exp_word_q, exp_word_d;
  logic                exp_last_q, exp_last_d;

  logic                w_xfer;
  logic                w_at_max;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [8:0]          w_enc;

  assign w_xfer    = in_valid & in_ready_q;
  assign w_at_max  = (ptr_q == C_PTR_MAX);
  // Pointer saturates at the top address; it never wraps.
  assign w_ptr_inc = w_at_max ? ptr_q : ptr_q + 1'b1;
  assign w_enc     = (in_op == 3'b111) ? {in_op, in_imm} : {in_op, in_ra, in_rb};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ovf_d      = ovf_q;
    exp_word_d = exp_word_q;
    exp_last_d = exp_last_q;

    if (start) begin
      // Start wins over everything, including a same-cycle transfer.
      state_d = S_RUN;
      ptr_d   = C_PTR_INIT;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (w_xfer) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = w_enc;
            ptr_d     = w_ptr_inc;
`ifdef ISA_ENCODER_BRANCH_EXPAND_EN
            if (in_op == 3'b110) begin
              wr_data_d  = {3'b111, in_imm};
              exp_word_d = {in_op, in_ra, in_rb};
              exp_last_d = in_last;
              if (w_at_max) begin
                // No room for the branch word: drop it and flag overflow.
                ovf_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_EXP;
              end
            end else
`endif
            if (in_last) begin
              state_d = S_DONE;
            end else if (w_at_max) begin
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_EXP: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = exp_word_q;
          ptr_d     = w_ptr_inc;
          if (exp_last_q) begin
            state_d = S_DONE;
          end else if (w_at_max) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          // IDLE and DONE wait for start; instruction inputs are ignored.
        end
      endcase
    end

    // Registered from next state only, so in_valid never reaches in_ready.
    in_ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= C_PTR_INIT;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      exp_word_q <= '0;
      exp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      exp_word_q <= exp_word_d;
      exp_last_q <= exp_last_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_EXP);
  assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire
